// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
//   div_op_e : request operation encoding (DIV, DIVU, REM, REMU)
//   state_e  : sequencer state encoding
package div_seq_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/div_seq_ctrl_sign_fix.sv
// div_sign_fix: combinational sign handling around the unsigned divider.
// Entry side turns signed operands into magnitudes; exit side negates the
// quotient/remainder as flagged and selects the requested one.
//   is_signed, rs1, rs2         -> mag1_c, mag2_c
//   neg_quot, neg_rem, sel_rem, dout -> quot_c, rem_c, result_c
module div_sign_fix #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_signed,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   mag1_c,
  output logic [XLEN-1:0]   mag2_c,
  input  logic              neg_quot,
  input  logic              neg_rem,
  input  logic              sel_rem,
  input  logic [2*XLEN-1:0] dout,
  output logic [XLEN-1:0]   quot_c,
  output logic [XLEN-1:0]   rem_c,
  output logic [XLEN-1:0]   result_c
);

  logic [XLEN-1:0] quot_raw;
  logic [XLEN-1:0] rem_raw;

  // Negating INT_MIN yields 2^(XLEN-1) unsigned, which is the right magnitude.
  always_comb begin
    quot_raw = dout[2*XLEN-1:XLEN];
    rem_raw  = dout[XLEN-1:0];
    mag1_c   = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    mag2_c   = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    quot_c   = neg_quot ? -quot_raw : quot_raw;
    rem_c    = neg_rem ? -rem_raw : rem_raw;
    result_c = sel_rem ? rem_c : quot_c;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences DIV/DIVU/REM/REMU requests onto an unsigned divider
// core, resolves divide-by-zero and signed overflow locally, and returns the
// sign-corrected result over a valid/ready handshake.
// Ports: clk, rst_n, flush; req_* (request in, req_ready out);
//        resp_* (result out, resp_ready in); div_dividend_*/div_divisor_*
//        (operand magnitudes to divider); div_dout_* (divider result in).
// Optional: define DIV_RESULT_REUSE_EN to reuse the last divider result for a
// repeated rs1/rs2/signedness (e.g. DIV followed by REM).
module div_seq_ctrl #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [XLEN-1:0]   div_dividend_tdata,
  output logic              div_dividend_tvalid,
  output logic [XLEN-1:0]   div_divisor_tdata,
  output logic              div_divisor_tvalid,
  input  logic [2*XLEN-1:0] div_dout_tdata,
  input  logic              div_dout_tvalid
);
  import div_seq_ctrl_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic             sel_rem_q, sel_rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  mag1_q, mag1_d, mag2_q, mag2_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_valid_q, resp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             div_tvalid_q, div_tvalid_d;

  logic             req_signed_c, accept_c, reuse_hit_c;
  logic [XLEN-1:0]  mag1_c, mag2_c, quot_fix_c, rem_fix_c, result_c, reuse_data_c;

  assign req_signed_c = ~req_op[0];
  assign accept_c     = req_valid && (state_q == IDLE) && !flush;

  div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .is_signed (req_signed_c),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .mag1_c    (mag1_c),
    .mag2_c    (mag2_c),
    .neg_quot  (neg_quot_q),
    .neg_rem   (neg_rem_q),
    .sel_rem   (sel_rem_q),
    .dout      (div_dout_tdata),
    .quot_c    (quot_fix_c),
    .rem_c     (rem_fix_c),
    .result_c  (result_c)
  );

`ifdef DIV_RESULT_REUSE_EN
  // Key of the in-flight request plus the last completed divider result.
  logic            key_signed_q, store_vld_q, store_signed_q, store_en_c;
  logic [XLEN-1:0] key_rs1_q, key_rs2_q, store_rs1_q, store_rs2_q, store_quot_q, store_rem_q;

  assign store_en_c   = (state_q == WAIT) && div_dout_tvalid && !flush;
  assign reuse_hit_c  = store_vld_q && (store_rs1_q == req_rs1) && (store_rs2_q == req_rs2)
                        && (store_signed_q == req_signed_c);
  assign reuse_data_c = req_op[1] ? store_rem_q : store_quot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_signed_q   <= 1'b0;
      key_rs1_q      <= '0;
      key_rs2_q      <= '0;
      store_vld_q    <= 1'b0;
      store_signed_q <= 1'b0;
      store_rs1_q    <= '0;
      store_rs2_q    <= '0;
      store_quot_q   <= '0;
      store_rem_q    <= '0;
    end else begin
      if (accept_c) begin
        key_signed_q <= req_signed_c;
        key_rs1_q    <= req_rs1;
        key_rs2_q    <= req_rs2;
      end
      if (store_en_c) begin
        store_vld_q    <= 1'b1;
        store_signed_q <= key_signed_q;
        store_rs1_q    <= key_rs1_q;
        store_rs2_q    <= key_rs2_q;
        store_quot_q   <= quot_fix_c;
        store_rem_q    <= rem_fix_c;
      end
    end
  end
`else
  logic unused_fix_c;

  assign reuse_hit_c  = 1'b0;
  assign reuse_data_c = '0;
  assign unused_fix_c = ^{quot_fix_c, rem_fix_c};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sel_rem_d    = sel_rem_q;
    neg_quot_d   = neg_quot_q;
    neg_rem_d    = neg_rem_q;
    mag1_d       = mag1_q;
    mag2_d       = mag2_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          sel_rem_d  = req_op[1];
          neg_quot_d = req_signed_c & (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]);
          neg_rem_d  = req_signed_c & req_rs1[XLEN-1];
          mag1_d     = mag1_c;
          mag2_d     = mag2_c;
          resp_tag_d = req_tag;
          if (req_rs2 == '0) begin
            resp_data_d = req_op[1] ? req_rs1 : '1;
            state_d     = DONE;
          end else if (req_signed_c && (req_rs1 == MIN_NEG) && (req_rs2 == '1)) begin
            resp_data_d = req_op[1] ? '0 : MIN_NEG;
            state_d     = DONE;
          end else if (reuse_hit_c) begin
            resp_data_d = reuse_data_c;
            state_d     = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        // A result coinciding with flush is the one being discarded.
        if (flush) begin
          state_d = div_dout_tvalid ? IDLE : DRAIN;
        end else if (div_dout_tvalid) begin
          resp_data_d = result_c;
          state_d     = DONE;
        end
      end
      DONE:    if (flush || resp_ready) state_d = IDLE;
      DRAIN:   if (div_dout_tvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == DONE);
    req_ready_d  = (state_d == IDLE);
    div_tvalid_d = (state_d == ISSUE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_rem_q    <= 1'b0;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      mag1_q       <= '0;
      mag2_q       <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      div_tvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_rem_q    <= sel_rem_d;
      neg_quot_q   <= neg_quot_d;
      neg_rem_q    <= neg_rem_d;
      mag1_q       <= mag1_d;
      mag2_q       <= mag2_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      div_tvalid_q <= div_tvalid_d;
    end
  end

  assign req_ready           = req_ready_q;
  assign resp_valid          = resp_valid_q;
  assign resp_data           = resp_data_q;
  assign resp_tag            = resp_tag_q;
  assign div_dividend_tdata  = mag1_q;
  assign div_divisor_tdata   = mag2_q;
  assign div_dividend_tvalid = div_tvalid_q;
  assign div_divisor_tvalid  = div_tvalid_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed RV32M cases, flush/reset scenarios and
// randomized operations checked against an arithmetic reference model, with a
// behavioural unsigned divider answering after a random latency.
`timescale 1ns/1ps
module tb_div_seq_ctrl;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef DIV_RESULT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = '0;
  logic [XLEN-1:0]   req_rs1 = '0;
  logic [XLEN-1:0]   req_rs2 = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [XLEN-1:0]   resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic [XLEN-1:0]   div_dividend_tdata;
  logic              div_dividend_tvalid;
  logic [XLEN-1:0]   div_divisor_tdata;
  logic              div_divisor_tvalid;
  logic [2*XLEN-1:0] div_dout_tdata = '0;
  logic              div_dout_tvalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  div_seq_ctrl #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush               (flush),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op              (req_op),
    .req_rs1             (req_rs1),
    .req_rs2             (req_rs2),
    .req_tag             (req_tag),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .resp_tag            (resp_tag),
    .div_dividend_tdata  (div_dividend_tdata),
    .div_dividend_tvalid (div_dividend_tvalid),
    .div_divisor_tdata   (div_divisor_tdata),
    .div_divisor_tvalid  (div_divisor_tvalid),
    .div_dout_tdata      (div_dout_tdata),
    .div_dout_tvalid     (div_dout_tvalid)
  );

  always #5 clk = ~clk;

  // Behavioural divider: captures operands whenever both tvalids are high and
  // answers after fixed_lat (or a random 1..6) cycles, with no notion of flush.
  int          issue_cnt = 0;
  int          bad_tv = 0;
  int          fixed_lat = 0;
  bit          dv_busy = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = '0;
  logic [31:0] last_dd = '0;
  logic [31:0] last_ds = '0;

  initial begin
    forever begin
      @(negedge clk);
      div_dout_tvalid = 1'b0;
      if (dv_busy) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_dout_tvalid = 1'b1;
          div_dout_tdata  = dv_res;
          dv_busy         = 1'b0;
        end
      end
      if (div_dividend_tvalid !== div_divisor_tvalid) bad_tv++;
      if (div_dividend_tvalid === 1'b1 && div_divisor_tvalid === 1'b1) begin
        issue_cnt++;
        last_dd = div_dividend_tdata;
        last_ds = div_divisor_tdata;
        dv_busy = 1'b1;
        dv_cnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
        if (div_divisor_tdata == '0) dv_res = '1;
        else dv_res = {div_dividend_tdata / div_divisor_tdata, div_dividend_tdata % div_divisor_tdata};
      end
    end
  end

  // Model of the reuse store: last operand set that completed on the divider.
  bit          st_vld = 1'b0;
  bit          st_s = 1'b0;
  logic [31:0] st_a = '0;
  logic [31:0] st_b = '0;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? (a % b) : (a / b);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int hold, input string name);
    logic [31:0] exp;
    bit          exp_issue;
    int          ic0;
    int          waited;
    exp = ref_result(op, a, b);
    exp_issue = (b != 32'd0) && !(!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                && !(REUSE && st_vld && st_a == a && st_b == b && st_s == !op[0]);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    ic0 = issue_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (resp_valid !== (exp_issue ? 1'b0 : 1'b1)) begin
      n_err++;
      $display("FAIL %s early_valid: resp_valid=%b required %b", name, resp_valid, !exp_issue);
    end
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: resp_valid=%b required 1", name, resp_valid);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_tag !== tag || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid=%b data=%h tag=%h rdy=%b required 1 %h %h 0",
                 name, i, resp_valid, resp_data, resp_tag, req_ready, exp, tag);
      end
    end
    n_cmp++;
    if (resp_data !== exp) begin
      n_err++;
      $display("FAIL %s data: got %h required %h", name, resp_data, exp);
    end
    n_cmp++;
    if (resp_tag !== tag) begin
      n_err++;
      $display("FAIL %s tag: got %h required %h", name, resp_tag, tag);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s handshake: valid=%b rdy=%b required 0 1", name, resp_valid, req_ready);
    end
    n_cmp++;
    if (issue_cnt - ic0 != int'(exp_issue)) begin
      n_err++;
      $display("FAIL %s issues: got %0d required %0d", name, issue_cnt - ic0, int'(exp_issue));
    end
    if (exp_issue) begin
      st_vld = 1'b1; st_a = a; st_b = b; st_s = !op[0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
    n_cmp++;
    if (div_dividend_tvalid !== 1'b0 || div_divisor_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_tvalid: got %b%b required 00", div_dividend_tvalid, div_divisor_tvalid);
    end
    n_cmp++;
    if (resp_data !== 32'd0) begin n_err++; $display("FAIL reset_resp_data: got %h required 0", resp_data); end
    n_cmp++;
    if (resp_tag !== 5'd0) begin n_err++; $display("FAIL reset_resp_tag: got %h required 0", resp_tag); end
    apply_reset();
  endtask

  task automatic test_directed();
    do_op(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd1, 0, "div_m20_3");
    n_cmp++;
    if (last_dd !== 32'd20 || last_ds !== 32'd3) begin
      n_err++; $display("FAIL abs_operands: got %h/%h required 14/3", last_dd, last_ds);
    end
    do_op(2'b10, 32'hFFFF_FFEC, 32'd3, 5'd2, 0, "rem_m20_3");
    do_op(2'b11, 32'd20, 32'd3, 5'd3, 0, "remu_20_3");
    do_op(2'b01, 32'd7, 32'd0, 5'd4, 0, "divu_by0");
    do_op(2'b10, 32'd7, 32'd0, 5'd5, 0, "rem_by0");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, "div_ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, "rem_ovf");
    do_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd8, 5, "hold5");
  endtask

  task automatic test_flush_wait();
    int bad;
    fixed_lat = 8;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_tag = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL drain_busy: req_ready=%b required 0", req_ready); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL drain_stale: resp_valid seen %0d cycles required 0", bad); end
    fixed_lat = 0;
    do_op(2'b01, 32'd100, 32'd10, 5'd11, 0, "after_drain");
  endtask

  task automatic test_flush_done_idle();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd7; req_rs2 = 32'd0; req_tag = 5'd12;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_done: valid=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
    req_valid = 1'b1; flush = 1'b1; req_tag = 5'd13;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_idle: valid=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_midop();
    int bad;
    fixed_lat = 6;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'd14;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    st_vld = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL reset_midop: %0d bad cycles required 0", bad); end
    fixed_lat = 0;
  endtask

  task automatic test_reuse();
    do_op(2'b00, 32'd50, 32'd7, 5'd15, 0, "reuse_div");
    do_op(2'b10, 32'd50, 32'd7, 5'd16, 0, "reuse_rem");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        a = pick_operand();
        b = pick_operand();
      end
      do_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_wait();
    test_flush_done_idle();
    test_reset_midop();
    test_reuse();
    test_random();
    n_cmp++;
    if (bad_tv != 0) begin n_err++; $display("FAIL tvalid_pair: %0d split cycles required 0", bad_tv); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing and sign-handling stage directly upstream of divider_wrapper in the RV32M execute path.
- Accepts DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed overflow locally.
- Sends operand magnitudes to the unsigned divider core, waits for its dout tvalid, selects quotient or remainder, applies the sign fix-up and returns the result with a valid/ready handshake.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside the operation.
- XLEN, 32, operand width; it must match the divider dividend/divisor width.

Ports:
- clk  in  1  core clock, also used to drive aclk_0 of the divider.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kills any in-flight operation.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_rs1  in  XLEN  dividend.
- req_rs2  in  XLEN  divisor.
- req_tag  in  TAG_W  destination tag.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  result.
- resp_tag  out  TAG_W  tag of the returned result.
- div_dividend_tdata  out  XLEN  dividend magnitude to the divider.
- div_dividend_tvalid  out  1  dividend valid.
- div_divisor_tdata  out  XLEN  divisor magnitude to the divider.
- div_divisor_tvalid  out  1  divisor valid.
- div_dout_tdata  in  2*XLEN  divider output: quotient in [63:32], remainder in [31:0].
- div_dout_tvalid  in  1  divider output valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; req_ready=1; resp_valid=0; both divider tvalids=0; resp_data=0; resp_tag=0.
- State machine: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - A request is accepted when req_valid and req_ready are both high.
  - Latched at accept: op, tag, signed flag (op[0]==0), neg_q = signed and (rs1[31] xor rs2[31]), neg_r = signed and rs1[31].
  - Magnitudes: |rs1| and |rs2| when signed, otherwise the raw values.
- Special cases (IDLE goes straight to DONE; resp_valid asserts on the cycle after accept; the divider is not issued):
  - rs2==0: quotient = all-ones; remainder = rs1.
  - Signed, rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- ISSUE: both tvalids high for exactly one cycle, then go to WAIT. The divider has no tready, so there is no backpressure.
- WAIT: on div_dout_tvalid, select quotient (DIV/DIVU) or remainder (REM/REMU), negate it if the corresponding neg flag is set, register it, then go to DONE.
- DONE:
  - resp_valid is held with data and tag stable until resp_ready is high.
  - After the handshake, return to IDLE; req_ready rises in the same cycle the state enters IDLE.
- div_dout_tvalid seen outside WAIT/DRAIN is ignored.
- Flush:
  - In ISSUE or WAIT: go to DRAIN and discard the next div_dout_tvalid, then go to IDLE.
  - In DONE: drop resp_valid and go to IDLE.
  - In IDLE: no effect; a request arriving in the same cycle as flush is not accepted.
  - In DRAIN: ignored.
- Reset mid-operation forces IDLE. A stale divider result arriving afterwards is ignored, per the outside-WAIT rule.
- Throughput: one operation outstanding at a time.

Optional Feature:
- Macro: DIV_RESULT_REUSE_EN.
- When defined:
  - On every completed divider issue, store rs1, rs2, the signed flag, the final quotient and the final remainder.
  - A later request with identical rs1/rs2/signed skips ISSUE/WAIT and goes IDLE to DONE; resp_valid asserts on the cycle after accept.
  - Covers the DIV-then-REM idiom.
  - The store is invalidated by reset only; flush leaves it intact.
- When undefined: every non-special request issues to the divider.

Decomposition:
- Shared package holds:
  - the div_op_e typedef (DIV, DIVU, REM, REMU);
  - the state enum;
  - constants XLEN, INT_MIN = 0x80000000, ALL_ONES.
- One natural sub-module: div_sign_fix, a combinational abs on entry and conditional negate plus select on exit.

Test Plan:
- DIV rs1=-20, rs2=3 -> resp_data = -6 (0xFFFFFFFA).
- REM rs1=-20, rs2=3 -> resp_data = -2. REMU rs1=20, rs2=3 -> resp_data = 2. Each takes divider latency + 3 cycles.
- DIVU rs1=7, rs2=0 -> resp_data = 0xFFFFFFFF, with no divider tvalid and resp_valid one cycle after accept. REM rs1=7, rs2=0 -> resp_data = 7.
- DIV rs1=0x80000000, rs2=-1 -> 0x80000000. REM with the same operands -> 0.
- Flush in WAIT, then a new DIVU 100/10 issued after DRAIN -> resp_data = 10. The stale result is never returned.
- resp_ready held low 5 cycles in DONE -> resp_valid, resp_data and resp_tag stay stable and req_ready stays 0. With DIV_RESULT_REUSE_EN: DIV 50/7 then REM 50/7 -> 7 and 1, and the second request causes no divider issue.
